// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event detector.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam int unsigned MS_PER_SEC = 32'd1000;

    // Width of a counter that must hold values up to the larger of the two thresholds.
    function automatic int unsigned cnt_width(input int unsigned long_ms, input int unsigned repeat_ms);
        int unsigned top;
        top = (long_ms > repeat_ms) ? long_ms : repeat_ms;
        return $clog2(top + 32'd1);
    endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: two-flop synchroniser, press/long/repeat FSM and ms counter.
module key_event_ch
    import key_event_pkg::*;
#(
    parameter int unsigned LongMs    = 1000,
    parameter int unsigned RepeatMs  = 200,
    parameter int unsigned ActiveLow = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic tick,
    output logic press,
    output logic released,
    output logic long,
    output logic repeated,
    output logic held
);

    localparam int unsigned CntW = cnt_width(LongMs, RepeatMs);
    localparam logic [CntW-1:0] LongCnt   = CntW'(LongMs);
    localparam logic [CntW-1:0] RepeatCnt = CntW'(RepeatMs);
    // Raw level of a released key; synchroniser flops rest here in reset.
    localparam logic IdleLvl = (ActiveLow != 0) ? 1'b1 : 1'b0;

    logic            sync1_r;
    logic            sync2_r;
    logic            key_act_s;
    state_t          state_r;
    state_t          state_nxt_s;
    logic [CntW-1:0] cnt_r;
    logic [CntW-1:0] cnt_nxt_s;
    logic [CntW-1:0] cnt_inc_s;
    logic            press_nxt_s;
    logic            release_nxt_s;
    logic            long_nxt_s;
    logic            repeat_nxt_s;

    // Two-flop synchroniser for the asynchronous key level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= IdleLvl;
            sync2_r <= IdleLvl;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    assign key_act_s = (ActiveLow != 0) ? ~sync2_r : sync2_r;
    assign cnt_inc_s = cnt_r + CntW'(1);

    // Next-state, counter and event decode; a release always takes priority over thresholds.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        long_nxt_s    = 1'b0;
        repeat_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_act_s) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = '0;
                    press_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESSED: begin
                if (!key_act_s) begin
                    state_nxt_s   = IDLE;
                    cnt_nxt_s     = '0;
                    release_nxt_s = 1'b1;
                end else if (tick) begin
                    if (cnt_inc_s == LongCnt) begin
                        state_nxt_s = LONG;
                        cnt_nxt_s   = '0;
                        long_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            LONG: begin
                if (!key_act_s) begin
                    state_nxt_s   = IDLE;
                    cnt_nxt_s     = '0;
                    release_nxt_s = 1'b1;
                end else if ((RepeatMs != 0) && tick) begin
                    if (cnt_inc_s == RepeatCnt) begin
                        cnt_nxt_s    = '0;
                        repeat_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    // Repeat disabled or no tick: counter holds.
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            press    <= 1'b0;
            released <= 1'b0;
            long     <= 1'b0;
            repeated <= 1'b0;
            held     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            press    <= press_nxt_s;
            released <= release_nxt_s;
            long     <= long_nxt_s;
            repeated <= repeat_nxt_s;
            held     <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: rtl/key_event.sv
// Multi-channel key event detector with a shared millisecond prescaler.
module key_event
    import key_event_pkg::*;
#(
    parameter int unsigned Size      = 4,
    parameter int unsigned ClkSpeed  = 1_000_000,
    parameter int unsigned LongMs    = 1000,
    parameter int unsigned RepeatMs  = 200,
    parameter int unsigned ActiveLow = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [Size-1:0] key_in,
    output logic [Size-1:0] press,
    output logic [Size-1:0] released,
    output logic [Size-1:0] long,
    output logic [Size-1:0] repeated,
    output logic [Size-1:0] held
);

    localparam int unsigned Div = ClkSpeed / MS_PER_SEC;
    localparam int unsigned PW  = (Div > 1) ? $clog2(Div) : 1;

    logic [PW-1:0] prescale_r;
    logic          tick_s;

    assign tick_s = (prescale_r == PW'(Div - 1));

    // Free-running prescaler; tick is high on the last count of each ms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_r <= '0;
        end else if (tick_s) begin
            prescale_r <= '0;
        end else begin
            prescale_r <= prescale_r + PW'(1);
        end
    end

    for (genvar i = 0; i < Size; i++) begin : g_ch
        key_event_ch #(
            .LongMs   (LongMs),
            .RepeatMs (RepeatMs),
            .ActiveLow(ActiveLow)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_in  (key_in[i]),
            .tick    (tick_s),
            .press   (press[i]),
            .released(released[i]),
            .long    (long[i]),
            .repeated(repeated[i]),
            .held    (held[i])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// Randomised and directed bench for key_event against a tick-counting reference model.
module tb_key_event;

    localparam int N       = 4;
    localparam int DIV     = 10;
    localparam int LONG_MS = 5;
    localparam int REP_MS  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_in = 4'hF;
    logic [N-1:0] press_a, rel_a, long_a, rpt_a, held_a;
    logic [N-1:0] press_b, rel_b, long_b, rpt_b, held_b;

    int total = 0;
    int bad = 0;

    // Reference model: synchroniser delay line, ms tick phase, per-key elapsed ticks.
    logic [N-1:0] s1, s2;
    int           edge_cnt;
    bit           mp [2][N];
    int           mt [2][N];
    logic [N-1:0] ep [2];
    logic [N-1:0] er [2];
    logic [N-1:0] el [2];
    logic [N-1:0] eq [2];
    logic [N-1:0] eh [2];

    // Observed pulse counters for scenario-level checks.
    int n_press [2][N];
    int n_rel   [2][N];
    int n_long  [2][N];
    int n_rpt   [2][N];
    int n_held  [2][N];

    key_event #(.Size(N), .ClkSpeed(10000), .LongMs(LONG_MS), .RepeatMs(REP_MS), .ActiveLow(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .press(press_a), .released(rel_a), .long(long_a), .repeated(rpt_a), .held(held_a)
    );

    key_event #(.Size(N), .ClkSpeed(10000), .LongMs(LONG_MS), .RepeatMs(0), .ActiveLow(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .press(press_b), .released(rel_b), .long(long_b), .repeated(rpt_b), .held(held_b)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                n_press[d][c] = 0; n_rel[d][c] = 0; n_long[d][c] = 0;
                n_rpt[d][c] = 0; n_held[d][c] = 0;
            end
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] seen;
        bit           tick;
        int           rep;
        if (!rst_n) begin
            s1 = 4'hF; s2 = 4'hF; edge_cnt = 0;
            for (int d = 0; d < 2; d++) begin
                ep[d] = '0; er[d] = '0; el[d] = '0; eq[d] = '0; eh[d] = '0;
                for (int c = 0; c < N; c++) begin
                    mp[d][c] = 1'b0; mt[d][c] = 0;
                end
            end
        end else begin
            seen = ~s2;
            s2 = s1;
            s1 = key_in;
            edge_cnt++;
            tick = (edge_cnt % DIV == 0);
            for (int d = 0; d < 2; d++) begin
                rep = (d == 0) ? REP_MS : 0;
                ep[d] = '0; er[d] = '0; el[d] = '0; eq[d] = '0;
                for (int c = 0; c < N; c++) begin
                    if (!mp[d][c] && seen[c]) begin
                        ep[d][c] = 1'b1; mp[d][c] = 1'b1; mt[d][c] = 0;
                    end else if (mp[d][c] && !seen[c]) begin
                        er[d][c] = 1'b1; mp[d][c] = 1'b0;
                    end else if (mp[d][c] && tick) begin
                        mt[d][c]++;
                        if (mt[d][c] == LONG_MS)
                            el[d][c] = 1'b1;
                        else if (rep > 0 && mt[d][c] > LONG_MS && (mt[d][c] - LONG_MS) % rep == 0)
                            eq[d][c] = 1'b1;
                    end
                    eh[d][c] = mp[d][c];
                end
            end
        end
    endtask

    task automatic compare();
        check_value("a.press", 32'(press_a), 32'(ep[0]));
        check_value("a.release", 32'(rel_a), 32'(er[0]));
        check_value("a.long", 32'(long_a), 32'(el[0]));
        check_value("a.repeat", 32'(rpt_a), 32'(eq[0]));
        check_value("a.held", 32'(held_a), 32'(eh[0]));
        check_value("b.press", 32'(press_b), 32'(ep[1]));
        check_value("b.release", 32'(rel_b), 32'(er[1]));
        check_value("b.long", 32'(long_b), 32'(el[1]));
        check_value("b.repeat", 32'(rpt_b), 32'(eq[1]));
        check_value("b.held", 32'(held_b), 32'(eh[1]));
        for (int c = 0; c < N; c++) begin
            check_value("a.excl", 32'($countones({press_a[c], rel_a[c], long_a[c], rpt_a[c]}) <= 1), 32'd1);
            check_value("b.excl", 32'($countones({press_b[c], rel_b[c], long_b[c], rpt_b[c]}) <= 1), 32'd1);
            n_press[0][c] += int'(press_a[c]); n_press[1][c] += int'(press_b[c]);
            n_rel[0][c]   += int'(rel_a[c]);   n_rel[1][c]   += int'(rel_b[c]);
            n_long[0][c]  += int'(long_a[c]);  n_long[1][c]  += int'(long_b[c]);
            n_rpt[0][c]   += int'(rpt_a[c]);   n_rpt[1][c]   += int'(rpt_b[c]);
            n_held[0][c]  += int'(held_a[c]);  n_held[1][c]  += int'(held_b[c]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // Assert reset between edges and confirm outputs clear without waiting for a clock.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check_value("rst_async_a", 32'({press_a, rel_a, long_a, rpt_a, held_a}), 32'd0);
        check_value("rst_async_b", 32'({press_b, rel_b, long_b, rpt_b, held_b}), 32'd0);
    endtask

    initial begin
        int p_idx;
        int l_idx;
        int t5;
        int got_press;

        // Reset state
        rst_n = 1'b0;
        key_in = 4'hF;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Short press on key 0
        clear_counts();
        key_in[0] = 1'b0;
        repeat (20) step();
        key_in[0] = 1'b1;
        repeat (10) step();
        check_value("short_held", 32'(n_held[0][0]), 32'd20);
        check_value("short_press", 32'(n_press[0][0]), 32'd1);
        check_value("short_release", 32'(n_rel[0][0]), 32'd1);
        check_value("short_long", 32'(n_long[0][0]), 32'd0);

        // Long hold on key 1
        clear_counts();
        p_idx = -1000; l_idx = 1000;
        key_in[1] = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (press_a[1]) p_idx = i;
            if (long_a[1]) l_idx = i;
        end
        key_in[1] = 1'b1;
        repeat (10) step();
        check_value("long_delay", 32'((l_idx - p_idx) >= 40 && (l_idx - p_idx) <= 53), 32'd1);
        check_value("long_count_a", 32'(n_long[0][1]), 32'd1);
        check_value("long_repeats_a", 32'(n_rpt[0][1]), 32'd3);
        check_value("long_repeats_b", 32'(n_rpt[1][1]), 32'd0);
        check_value("long_release", 32'(n_rel[0][1]), 32'd1);

        // Release seen on the exact threshold tick of key 2
        clear_counts();
        t5 = -100;
        key_in[2] = 1'b0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (press_a[2]) t5 = (edge_cnt / DIV + LONG_MS) * DIV;
            if (t5 > 0 && edge_cnt == t5 - 3) key_in[2] = 1'b1;
        end
        key_in[2] = 1'b1;
        check_value("race_release", 32'(n_rel[0][2]), 32'd1);
        check_value("race_no_long", 32'(n_long[0][2]), 32'd0);

        // Keys 0 and 3 together
        got_press = 0;
        key_in[0] = 1'b0; key_in[3] = 1'b0;
        for (int i = 0; i < 6 && got_press == 0; i++) begin
            step();
            if (press_a != 4'b0000) begin
                got_press = 1;
                check_value("multi_press", 32'(press_a), 32'b1001);
            end
        end
        check_value("multi_seen", 32'(got_press), 32'd1);
        repeat (8) step();
        key_in[0] = 1'b1; key_in[3] = 1'b1;
        repeat (8) step();

        // Reset while key 1 is in the long state, key kept held across reset
        clear_counts();
        key_in[1] = 1'b0;
        repeat (60) step();
        check_value("pre_rst_long", 32'(n_long[0][1]), 32'd1);
        async_reset();
        repeat (3) step();
        check_value("rst_no_release", 32'(n_rel[0][1]), 32'd0);
        rst_n = 1'b1;
        step();
        check_value("rst_press_e1", 32'(press_a), 32'd0);
        step();
        check_value("rst_press_e2", 32'(press_a), 32'd0);
        step();
        check_value("rst_press_e3", 32'(press_a), 32'b0010);
        repeat (10) step();
        key_in[1] = 1'b1;
        repeat (10) step();

        // Repeat disabled: hold key 3 for 200 cycles
        clear_counts();
        key_in[3] = 1'b0;
        repeat (200) step();
        key_in[3] = 1'b1;
        repeat (10) step();
        check_value("norep_long", 32'(n_long[1][3]), 32'd1);
        check_value("norep_repeat", 32'(n_rpt[1][3]), 32'd0);

        // Random key activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 39) == 0) key_in[c] = ~key_in[c];
            end
            if ($urandom_range(0, 999) == 0) begin
                async_reset();
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter Size, default 4, number of key channels.
REQ-002 Parameter ClkSpeed, default 1_000_000, clk frequency in Hz.
REQ-003 Parameter LongMs, default 1000, hold time in ms before long-press; legal range 1..65535.
REQ-004 Parameter RepeatMs, default 200, auto-repeat period in ms after long-press; 0 disables repeat.
REQ-005 Parameter ActiveLow, default 1; 1 means a pressed key drives 0.
REQ-006 clk  input  1  single system clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_in  input  Size  debounced key levels from the 20 ms debouncer; asynchronous to clk.
REQ-009 press  output  Size  one-cycle pulse on press.
REQ-010 release  output  Size  one-cycle pulse on release.
REQ-011 long  output  Size  one-cycle pulse when the hold reaches LongMs.
REQ-012 repeat  output  Size  one-cycle pulse every RepeatMs while held after long.
REQ-013 held  output  Size  level, 1 while the key is pressed (after synchronisation).

Function
REQ-014 Each key_in bit shall pass through a two-flop synchroniser, then be normalised to active-high using ActiveLow.
REQ-015 The shared ms tick shall be a one-cycle pulse every ClkSpeed/1000 clk cycles from a free-running prescaler, counting from reset.
REQ-016 Each channel FSM has states IDLE, PRESSED, LONG.
REQ-017 IDLE->PRESSED on a synchronised press: press pulses for one cycle, held=1, and the ms counter clears.
REQ-018 Latency: press and release pulses are registered and appear on the 3rd rising clk edge after key_in changes (set-up met).
REQ-019 PRESSED: the ms counter increments on each tick; on the tick where it reaches LongMs, long pulses and the FSM enters LONG with the counter cleared.
REQ-020 Press-to-long delay shall lie within (LongMs-1) ms and LongMs ms plus 3 cycles.
REQ-021 LONG with RepeatMs>0: the counter increments on each tick; on reaching RepeatMs, repeat pulses and the counter clears.
REQ-022 LONG with RepeatMs=0: repeat stays 0 and the counter is frozen.
REQ-023 Release in PRESSED or LONG: release pulses, held=0, the FSM returns to IDLE, and the counter clears.
REQ-024 Release in the same cycle as a long/repeat threshold: release wins and long/repeat is suppressed.
REQ-025 Channels shall be fully independent; simultaneous events on several channels shall all be reported in the same cycle.
REQ-026 The counter width shall be ceil(log2(max(LongMs,RepeatMs)+1)) and the counter shall never wrap.
REQ-027 At most one of press/release/long/repeat per channel shall be high in any cycle.

Reset
REQ-028 While rst_n=0: all outputs 0, all FSMs IDLE, counters and prescaler 0, synchroniser flops at the inactive key level.
REQ-029 Reset asserted mid-hold shall abort without a release pulse.
REQ-030 A key still held at reset release shall produce a press pulse 3 cycles after rst_n rises.

Structure
REQ-031 Package key_event_pkg shall hold the FSM state enum (IDLE, PRESSED, LONG) and the ms-per-second constant 1000.
REQ-032 Sub-module key_event_ch (synchroniser, FSM, counter for one key) shall be instantiated Size times by generate.
REQ-033 The prescaler shall live once in key_event and be shared by all channels.

Verification
REQ-034 Bench parameters: ClkSpeed=10000 (tick every 10 cycles), LongMs=5, RepeatMs=2, Size=4, ActiveLow=1.
REQ-035 Short press: key_in[0] 1->0 for 20 cycles -> press[0] at edge 3, release[0] at edge 3 after the rising edge, no long; held[0] high for 20 cycles.
REQ-036 Long hold: key_in[1]=0 for 120 cycles -> long[1] 40-53 cycles after press, then repeat[1] every 20 cycles, then release[1].
REQ-037 Race: release timed on the threshold cycle -> release[2] only, no long[2].
REQ-038 Multi-key: keys 0 and 3 pressed in the same cycle -> press[0] and press[3] in the same cycle.
REQ-039 Reset mid-hold: rst_n low during LONG -> all outputs 0 immediately with no release; key still held at deassert -> press 3 cycles later.
REQ-040 RepeatMs=0 rerun: hold 200 cycles -> exactly one long and zero repeat pulses.
